pipe_mem_stage: RTL and testbench
=================================

Name: pipe_mem_stage

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register.
- Consumes the registered EX/MEM bundle: dmem controls, ALU result as address, rt data as store data, and writeback tags.
- Performs aligned byte, halfword and word loads and stores over a req/ack data-memory port, stalling upstream until the port acknowledges.
- Produces a registered bundle for the MEM/WB register: a writeback value from either the load data or the ALU result, plus the writeback tags.

Parameters:
- ADDR_W, 32, data-memory address width; the address is taken from in_alu_result[ADDR_W-1:0].

Ports:
- in_clk  input  1  clock; all state updates on the rising edge.
- in_rst_n  input  1  reset, synchronous, active-low.
- in_dmem_ena  input  1  instruction accesses data memory.
- in_dmem_wena  input  1  1 = store, 0 = load.
- in_dmem_type  input  2  access size: 00 word, 01 half signed, 10 byte signed, 11 byte unsigned.
- in_rt_data  input  32  store data.
- in_rd_waddr  input  5  destination register.
- in_rd_sel  input  1  writeback source: 1 = load data, 0 = ALU result.
- in_rd_wena  input  1  register write enable.
- in_alu_result  input  32  ALU result, also the byte address.
- in_mem_ack  input  1  memory completes the current request this cycle.
- in_mem_rdata  input  32  read word; valid while in_mem_ack = 1.
- out_mem_req  output  1  memory request.
- out_mem_we  output  1  write strobe.
- out_mem_addr  output  ADDR_W  word-aligned address (low two bits are 0).
- out_mem_be  output  4  byte enables.
- out_mem_wdata  output  32  lane-replicated store data.
- out_stall  output  1  upstream (PC, IF/ID, ID/EX, EX/MEM) must hold this cycle.
- out_valid  output  1  registered: the writeback bundle is valid.
- out_wb_data  output  32  registered writeback value.
- out_rd_waddr  output  5  registered destination register.
- out_rd_wena  output  1  registered write enable; forced to 0 on a bubble or misalignment.
- out_misalign  output  1  registered one-cycle flag for a misaligned access.

Behaviour:
- Reset: in_rst_n = 0 at a clock edge clears the FSM to IDLE and clears every registered output to 0.
  - out_mem_req, out_mem_we and out_stall are decoded from state, so they fall in the cycle after the reset edge.
  - An outstanding request is abandoned without waiting for ack.
- Alignment rules:
  - Word access: misaligned if addr[1:0] != 0.
  - Halfword access: misaligned if addr[0] = 1.
  - Byte access: never misaligned.
- FSM states: IDLE, REQ.
- IDLE with in_dmem_ena = 0:
  - At the next edge: out_wb_data = in_alu_result, out_rd_waddr and out_rd_wena passed through, out_valid = 1, out_misalign = 0.
  - Latency is 1 cycle; no stall.
- IDLE with in_dmem_ena = 1 and misaligned:
  - No memory request is issued.
  - At the next edge: out_valid = 1, out_rd_wena = 0, out_misalign = 1.
- IDLE with in_dmem_ena = 1 and aligned:
  - out_stall = 1 combinationally this cycle.
  - The block latches word address, byte enables, write data, write flag, type, byte offset, rd_sel, rd_waddr, rd_wena and alu_result.
  - Next state is REQ; at that edge out_valid = 0 and out_rd_wena = 0 (bubble).
- REQ:
  - out_mem_req = 1 and out_mem_we = latched write flag; address, byte enables and write data are stable from the latches.
  - out_stall = ~in_mem_ack.
  - Without ack: stay in REQ and register a bubble.
  - With ack, at that edge: go to IDLE, out_valid = 1, out_rd_waddr and out_rd_wena from the latches.
    - out_wb_data = extracted load value if rd_sel = 1, otherwise the latched alu_result.
  - Minimum memory-instruction latency is 2 cycles (ack arriving in the first REQ cycle).
  - The instruction presented in the following IDLE cycle is the next upstream instruction.
- Byte enables:
  - Word access: 1111.
  - Halfword access: 0011 when addr[1] = 0, 1100 when addr[1] = 1.
  - Byte access: 0001 shifted left by addr[1:0].
- Store data:
  - Byte store: rt[7:0] replicated to all 4 lanes.
  - Halfword store: rt[15:0] replicated to both halves.
  - Word store: rt unchanged.
- Load extraction:
  - Select the lane by the latched byte offset.
  - Sign-extend for types 01 and 10; zero-extend for type 11.
- Store completion: a store writes back nothing unless in_rd_wena was set. out_valid is still 1 on ack.
- Back-to-back memory instructions: each spends one IDLE cycle before its REQ; there is no overlap.
- in_mem_ack while in IDLE is ignored.

Decomposition:
- Shared package pipe_pkg holds:
  - DMEM_W = 2'b00, DMEM_H = 2'b01, DMEM_B = 2'b10, DMEM_BU = 2'b11.
  - FSM state encoding.
  - The RD_SEL_MEM / RD_SEL_ALU constants.
- One sub-module, mem_align: purely combinational. It provides:
  - Byte-enable generation.
  - Store-lane replication.
  - Load extraction with sign or zero extension.
  - The misalign check.
- The FSM and output registers live in pipe_mem_stage.

Test Plan:
- ALU op: dmem_ena = 0, alu_result = 0x0000_1234, rd_waddr = 5, rd_wena = 1 -> next edge: out_valid = 1, out_wb_data = 0x1234, out_rd_waddr = 5, out_stall never asserted.
- Word load with ack after 3 REQ cycles: addr 0x100, rdata 0xDEADBEEF, rd_sel = 1 -> out_stall high for 4 cycles, out_mem_addr = 0x100, out_mem_be = 1111, out_wb_data = 0xDEADBEEF one edge after ack.
- Signed byte load: addr 0x103, rdata 0x80_00_00_00 -> be = 1000, out_wb_data = 0xFFFF_FF80; same access with type 11 -> 0x0000_0080.
- Halfword store: addr 0x202, rt = 0x1234_ABCD -> out_mem_addr = 0x200, be = 1100, wdata = 0xABCD_ABCD, out_mem_we = 1, out_rd_wena = 0 after ack.
- Misaligned word load at 0x101 -> out_mem_req stays 0, no stall, next edge: out_misalign = 1, out_rd_wena = 0.
- Reset mid-REQ: in_rst_n = 0 while waiting for ack -> after the edge: out_mem_req = 0, out_stall = 0, all registered outputs 0, FSM in IDLE; a late ack is ignored.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the memory-access pipeline stage.
package pipe_pkg;

  // Data-memory access sizes as carried in the EX/MEM bundle.
  localparam logic [1:0] DMEM_W  = 2'b00;  // word
  localparam logic [1:0] DMEM_H  = 2'b01;  // halfword, sign-extended
  localparam logic [1:0] DMEM_B  = 2'b10;  // byte, sign-extended
  localparam logic [1:0] DMEM_BU = 2'b11;  // byte, zero-extended

  // Writeback source select.
  localparam logic RD_SEL_MEM = 1'b1;
  localparam logic RD_SEL_ALU = 1'b0;

  // Memory-port FSM.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Everything captured from the EX/MEM bundle when an access is launched.
  typedef struct packed {
    logic        we;
    logic [1:0]  dtype;
    logic [1:0]  offset;
    logic        rd_sel;
    logic [4:0]  rd_waddr;
    logic        rd_wena;
    logic [31:0] alu_result;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_op_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables, store replication, misalign
// detection for the incoming access, and load extraction for the latched one.
module mem_align
  import pipe_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  dmem_type,
  input  logic [31:0] st_data,
  input  logic [1:0]  ld_offset,
  input  logic [1:0]  ld_type,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic [31:0] ld_data
);

  logic [15:0] lane;

  // Store-side decode for the access presented by EX/MEM.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    be       = 4'b1111;
    wdata    = st_data;
    misalign = 1'b0;
    case (dmem_type)
      DMEM_W: misalign = |addr_lo;
      DMEM_H: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{st_data[15:0]}};
        misalign = addr_lo[0];
      end
      DMEM_B, DMEM_BU: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{st_data[7:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0.
  assign lane = 16'(rdata >> {ld_offset, 3'b000});

  // Load extraction with sign or zero extension.
  always_comb begin
    ld_data = rdata;
    case (ld_type)
      DMEM_H:  ld_data = {{16{lane[15]}}, lane[15:0]};
      DMEM_B:  ld_data = {{24{lane[7]}}, lane[7:0]};
      DMEM_BU: ld_data = {24'h0, lane[7:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_mem_stage.sv
// Memory-access stage: drives a req/ack data-memory port from the EX/MEM
// bundle, stalls upstream while an access is in flight, and registers the
// MEM/WB writeback bundle.
module pipe_mem_stage
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_dmem_ena,
  input  logic              in_dmem_wena,
  input  logic [1:0]        in_dmem_type,
  input  logic [31:0]       in_rt_data,
  input  logic [4:0]        in_rd_waddr,
  input  logic              in_rd_sel,
  input  logic              in_rd_wena,
  input  logic [31:0]       in_alu_result,
  input  logic              in_mem_ack,
  input  logic [31:0]       in_mem_rdata,
  output logic              out_mem_req,
  output logic              out_mem_we,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic [3:0]        out_mem_be,
  output logic [31:0]       out_mem_wdata,
  output logic              out_stall,
  output logic              out_valid,
  output logic [31:0]       out_wb_data,
  output logic [4:0]        out_rd_waddr,
  output logic              out_rd_wena,
  output logic              out_misalign
);

  state_e            state_q, state_d;
  mem_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;

  logic [3:0]  be;
  logic [31:0] wdata;
  logic        misalign;
  logic [31:0] ld_data;
  logic [31:0] ack_wb;
  logic        start;

  mem_align u_align (
    .addr_lo   (in_alu_result[1:0]),
    .dmem_type (in_dmem_type),
    .st_data   (in_rt_data),
    .ld_offset (op_q.offset),
    .ld_type   (op_q.dtype),
    .rdata     (in_mem_rdata),
    .be        (be),
    .wdata     (wdata),
    .misalign  (misalign),
    .ld_data   (ld_data)
  );

  // An aligned memory instruction seen in IDLE launches a request.
  assign start = (state_q == ST_IDLE) && in_dmem_ena && !misalign;

  // Next state and upstream stall.
  always_comb begin
    state_d   = state_q;
    out_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_REQ;
          out_stall = 1'b1;
        end
      end
      ST_REQ: begin
        out_stall = ~in_mem_ack;
        if (in_mem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Port strobes follow the state; address, enables and data come from the latches.
  assign out_mem_req   = (state_q == ST_REQ);
  assign out_mem_we    = out_mem_req & op_q.we;
  assign out_mem_addr  = addr_q;
  assign out_mem_be    = op_q.be;
  assign out_mem_wdata = op_q.wdata;

  // Writeback source for a completed access.
  always_comb begin
    ack_wb = op_q.alu_result;
    case (op_q.rd_sel)
      RD_SEL_MEM: ack_wb = ld_data;
      RD_SEL_ALU: ack_wb = op_q.alu_result;
      default: ;
    endcase
  end

  // Capture the access when it launches.
  // NOTE: these are pure data latches qualified by start; they carry no reset because the FSM never reads them outside REQ.
  always_ff @(posedge in_clk) begin
    if (start) begin
      op_q.we         <= in_dmem_wena;
      op_q.dtype      <= in_dmem_type;
      op_q.offset     <= in_alu_result[1:0];
      op_q.rd_sel     <= in_rd_sel;
      op_q.rd_waddr   <= in_rd_waddr;
      op_q.rd_wena    <= in_rd_wena;
      op_q.alu_result <= in_alu_result;
      op_q.be         <= be;
      op_q.wdata      <= wdata;
      addr_q          <= {in_alu_result[ADDR_W-1:2], 2'b00};
    end
  end

  // FSM state and the MEM/WB output register.
  always_ff @(posedge in_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!in_rst_n) begin
      state_q      <= ST_IDLE;
      out_valid    <= 1'b0;
      out_wb_data  <= '0;
      out_rd_waddr <= '0;
      out_rd_wena  <= 1'b0;
      out_misalign <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid    <= 1'b0;
      out_rd_wena  <= 1'b0;
      out_misalign <= 1'b0;
      if (state_q == ST_REQ) begin
        if (in_mem_ack) begin
          out_valid    <= 1'b1;
          out_wb_data  <= ack_wb;
          out_rd_waddr <= op_q.rd_waddr;
          out_rd_wena  <= op_q.rd_wena;
        end
      end else if (!in_dmem_ena) begin
        out_valid    <= 1'b1;
        out_wb_data  <= in_alu_result;
        out_rd_waddr <= in_rd_waddr;
        out_rd_wena  <= in_rd_wena;
      end else if (misalign) begin
        out_valid    <= 1'b1;
        out_wb_data  <= in_alu_result;
        out_rd_waddr <= in_rd_waddr;
        out_misalign <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Scoreboard bench for pipe_mem_stage: a driver issues instructions and
// pushes expected results computed from a byte-level memory model; a
// monitor pops and compares on out_valid; a responder models the memory.
module tb_pipe_mem_stage;
  import pipe_pkg::*;

  logic        in_clk = 1'b0;
  logic        in_rst_n;
  logic        in_dmem_ena, in_dmem_wena;
  logic [1:0]  in_dmem_type;
  logic [31:0] in_rt_data;
  logic [4:0]  in_rd_waddr;
  logic        in_rd_sel, in_rd_wena;
  logic [31:0] in_alu_result;
  logic        in_mem_ack;
  logic [31:0] in_mem_rdata;
  logic        out_mem_req, out_mem_we;
  logic [31:0] out_mem_addr;
  logic [3:0]  out_mem_be;
  logic [31:0] out_mem_wdata;
  logic        out_stall, out_valid;
  logic [31:0] out_wb_data;
  logic [4:0]  out_rd_waddr;
  logic        out_rd_wena, out_misalign;

  always #5 in_clk = ~in_clk;

  pipe_mem_stage #(.ADDR_W(32)) dut (
    .in_clk        (in_clk),
    .in_rst_n      (in_rst_n),
    .in_dmem_ena   (in_dmem_ena),
    .in_dmem_wena  (in_dmem_wena),
    .in_dmem_type  (in_dmem_type),
    .in_rt_data    (in_rt_data),
    .in_rd_waddr   (in_rd_waddr),
    .in_rd_sel     (in_rd_sel),
    .in_rd_wena    (in_rd_wena),
    .in_alu_result (in_alu_result),
    .in_mem_ack    (in_mem_ack),
    .in_mem_rdata  (in_mem_rdata),
    .out_mem_req   (out_mem_req),
    .out_mem_we    (out_mem_we),
    .out_mem_addr  (out_mem_addr),
    .out_mem_be    (out_mem_be),
    .out_mem_wdata (out_mem_wdata),
    .out_stall     (out_stall),
    .out_valid     (out_valid),
    .out_wb_data   (out_wb_data),
    .out_rd_waddr  (out_rd_waddr),
    .out_rd_wena   (out_rd_wena),
    .out_misalign  (out_misalign)
  );

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  waddr;
    logic        wena;
    logic        mis;
    bit          chk_data;
    bit          chk_waddr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];

  logic [7:0] ref_mem [256];  // reference model memory
  logic [7:0] mem     [256];  // responder memory, written only by DUT stores

  int total = 0;
  int bad   = 0;
  int force_lat = -1;
  int last_lat  = 0;
  bit resp_en   = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] t);
    if (t == DMEM_W) return 4;
    if (t == DMEM_H) return 2;
    return 1;
  endfunction

  task automatic set_word(input int base, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      ref_mem[base + i] = w[8*i +: 8];
      mem[base + i]     = w[8*i +: 8];
    end
  endtask

  // Issue one instruction: compute expectations, present it, hold until consumed.
  task automatic issue(input logic ena, input logic we, input logic [1:0] typ,
                       input logic [31:0] addr, input logic [31:0] rt,
                       input logic [4:0] waddr, input logic sel, input logic wena);
    int n, off, cnt, idx;
    bit mis, mem_op;
    exp_t e;
    req_t r;
    logic [31:0] val;
    n      = nbytes(typ);
    off    = int'(addr[1:0]);
    mis    = ena && ((off % n) != 0);
    mem_op = ena && !mis;
    e.waddr = waddr; e.mis = mis; e.chk_data = 1'b1; e.chk_waddr = 1'b1;
    if (!ena) begin
      e.wb = addr; e.wena = wena;
    end else if (mis) begin
      e.wb = '0; e.wena = 1'b0; e.chk_data = 1'b0; e.chk_waddr = 1'b0;
    end else begin
      val = '0;
      for (int i = 0; i < n; i++) begin
        idx = (int'(addr[7:0]) + i) & 255;
        val = val | (32'(ref_mem[idx]) << (8 * i));
      end
      if (typ == DMEM_H && val[15]) val = val | 32'hFFFF_0000;
      if (typ == DMEM_B && val[7])  val = val | 32'hFFFF_FF00;
      r.addr = addr & ~32'h3;
      r.we   = we;
      r.be   = '0;
      for (int i = 0; i < n; i++) r.be[off + i] = 1'b1;
      for (int k = 0; k < 4; k++) r.wdata[8*k +: 8] = rt[8*(k % n) +: 8];
      if (we) begin
        for (int i = 0; i < n; i++) begin
          idx = (int'(addr[7:0]) + i) & 255;
          ref_mem[idx] = rt[8*i +: 8];
        end
      end
      req_q.push_back(r);
      e.wena     = wena;
      e.wb       = sel ? val : addr;
      e.chk_data = !(we && sel);
    end
    exp_q.push_back(e);

    in_dmem_ena = ena; in_dmem_wena = we; in_dmem_type = typ; in_alu_result = addr;
    in_rt_data = rt; in_rd_waddr = waddr; in_rd_sel = sel; in_rd_wena = wena;

    cnt = 0;
    forever begin
      @(negedge in_clk);
      if (!out_stall) break;
      cnt++;
      if (cnt > 50) begin
        $display("FAIL stall_bound: stall held %0d cycles", cnt);
        break;
      end
    end
    check("stall_cycles", cnt, mem_op ? 1 + last_lat : 0);
    @(posedge in_clk); #1;
  endtask

  // Memory responder: checks each new request, acks after a chosen latency.
  initial begin
    bit   busy = 1'b0;
    int   wait_cnt = 0;
    int   base;
    req_t r;
    in_mem_ack = 1'b0;
    in_mem_rdata = '0;
    forever begin
      @(posedge in_clk); #1;
      in_mem_rdata = $urandom();
      if (!resp_en) begin
        in_mem_ack = 1'b1;
        busy = 1'b0;
      end else begin
        in_mem_ack = 1'b0;
        if (!in_rst_n) begin
          busy = 1'b0;
        end else if (out_mem_req) begin
          if (!busy) begin
            busy = 1'b1;
            if (req_q.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_req: addr 0x%08h with none expected", out_mem_addr);
            end else begin
              r = req_q.pop_front();
              check("req_addr", out_mem_addr, r.addr);
              check("req_be", out_mem_be, r.be);
              check("req_we", out_mem_we, r.we);
              if (r.we) check("req_wdata", out_mem_wdata, r.wdata);
            end
            wait_cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            last_lat = wait_cnt;
          end
          if (wait_cnt == 0) begin
            base = int'({out_mem_addr[7:2], 2'b00});
            in_mem_rdata = {mem[base+3], mem[base+2], mem[base+1], mem[base]};
            in_mem_ack = 1'b1;
            if (out_mem_we) begin
              for (int k = 0; k < 4; k++)
                if (out_mem_be[k]) mem[base + k] = out_mem_wdata[8*k +: 8];
            end
            busy = 1'b0;
          end else begin
            wait_cnt--;
          end
        end
      end
    end
  end

  // Monitor: pops one expectation per valid writeback; bubbles must be quiet.
  initial begin
    exp_t e;
    forever begin
      @(negedge in_clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid: wb 0x%08h with none expected", out_wb_data);
        end else begin
          e = exp_q.pop_front();
          check("wb_wena", out_rd_wena, e.wena);
          check("wb_misalign", out_misalign, e.mis);
          if (e.chk_waddr) check("wb_waddr", out_rd_waddr, e.waddr);
          if (e.chk_data) check("wb_data", out_wb_data, e.wb);
        end
      end else begin
        check("bubble_flags", {out_rd_wena, out_misalign}, 2'b00);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_wb_data"}, out_wb_data, 32'h0);
    check({tag, "_waddr"}, out_rd_waddr, 5'd0);
    check({tag, "_wena"}, out_rd_wena, 1'b0);
    check({tag, "_misalign"}, out_misalign, 1'b0);
    check({tag, "_req"}, out_mem_req, 1'b0);
    check({tag, "_stall"}, out_stall, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  t;
    req_t        r;
    in_rst_n = 1'b0;
    in_dmem_ena = 1'b0; in_dmem_wena = 1'b0; in_dmem_type = DMEM_W;
    in_rt_data = '0; in_rd_waddr = '0; in_rd_sel = 1'b0; in_rd_wena = 1'b0;
    in_alu_result = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom());
      mem[i] = ref_mem[i];
    end

    repeat (3) @(posedge in_clk);
    #1;
    check_reset_state("rst");
    in_rst_n = 1'b1;

    // Directed cases.
    issue(1'b0, 1'b0, DMEM_W, 32'h0000_1234, 32'h5555_5555, 5'd5, 1'b0, 1'b1);
    set_word(0, 32'hDEAD_BEEF);
    force_lat = 3;
    issue(1'b1, 1'b0, DMEM_W, 32'h0000_0100, 32'h0, 5'd7, RD_SEL_MEM, 1'b1);
    force_lat = -1;
    set_word(0, 32'h8000_0000);
    issue(1'b1, 1'b0, DMEM_B,  32'h0000_0103, 32'h0, 5'd8, RD_SEL_MEM, 1'b1);
    issue(1'b1, 1'b0, DMEM_BU, 32'h0000_0103, 32'h0, 5'd9, RD_SEL_MEM, 1'b1);
    issue(1'b1, 1'b1, DMEM_H,  32'h0000_0202, 32'h1234_ABCD, 5'd10, RD_SEL_ALU, 1'b0);
    issue(1'b1, 1'b0, DMEM_W,  32'h0000_0101, 32'h0, 5'd11, RD_SEL_MEM, 1'b1);
    issue(1'b1, 1'b0, DMEM_H,  32'h0000_0203, 32'h0, 5'd12, RD_SEL_MEM, 1'b1);

    // Randomized mix of ALU ops, loads and stores.
    repeat (300) begin
      a = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 255));
      t = 2'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 2) != 0), 1'($urandom()), t, a, $urandom(),
            5'($urandom()), 1'($urandom()), 1'($urandom()));
    end

    // Reset while a request waits for ack: the request is abandoned.
    r.addr = 32'h0000_0040; r.be = 4'b1111; r.we = 1'b0; r.wdata = 32'h0;
    req_q.push_back(r);
    force_lat = 1000;
    in_dmem_ena = 1'b1; in_dmem_wena = 1'b0; in_dmem_type = DMEM_W;
    in_alu_result = 32'h0000_0040; in_rd_waddr = 5'd3; in_rd_sel = 1'b1; in_rd_wena = 1'b1;
    repeat (3) @(posedge in_clk);
    #1;
    check("req_pending", out_mem_req, 1'b1);
    in_rst_n = 1'b0;
    in_dmem_ena = 1'b0;
    @(posedge in_clk); #1;
    check_reset_state("midreq");
    force_lat = -1;

    // A stray ack after reset, in IDLE, must not launch anything.
    resp_en = 1'b0;
    @(posedge in_clk); #2;
    in_rst_n = 1'b1;
    issue(1'b0, 1'b0, DMEM_W, 32'h0000_0ACE, 32'h0, 5'd17, 1'b0, 1'b1);
    check("late_ack_req", out_mem_req, 1'b0);
    in_rst_n = 1'b0;
    resp_en = 1'b1;
    repeat (3) @(posedge in_clk);
    #1;
    check("exp_drained", exp_q.size(), 0);
    check("req_drained", req_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
